pulse_seq_ctrl: RTL and testbench

PULSE_SEQ_CTRL -- requirements
Module: pulse_seq_ctrl

---
 rtl/pulse_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_pulse_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_seq_ctrl.sv
// pulse_seq_ctrl: steps an external interval timer through a programmable
// table of state durations, optionally repeating the pass several times.
// Every output is registered. Each state is one ARM cycle (timer held off so
// it restarts) followed by a RUN phase that lasts until the timer reports
// time_up.
module pulse_seq_ctrl (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [21:0] cfg_data,
    input  logic [3:0]  seq_len,
    input  logic [7:0]  loop_cnt,
    input  logic        seq_start,
    input  logic        seq_abort,
    input  logic        time_up,
    output logic [21:0] timer_data,
    output logic        work_n,
    output logic        state_start,
    output logic        state_over_n,
    output logic [3:0]  state_idx,
    output logic [7:0]  loop_idx,
    output logic        busy,
    output logic        seq_done
);

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

    state_t      state, state_nx;
    logic [21:0] tbl [16];
    logic [3:0]  idx_nx;
    logic [7:0]  loop_nx;
    logic        td_load;
    logic [3:0]  td_addr;

    // A zero duration would never let the timer fire; clamp it to one cycle.
    function automatic logic [21:0] dur_of(input logic [21:0] d);
        return (d == 22'd0) ? 22'd1 : d;
    endfunction

    // Duration table: writable only while the sequencer is idle.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) tbl[i] <= '0;
        end else if (cfg_we && !busy) begin
            tbl[cfg_addr] <= cfg_data;
        end
    end

    // State register.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic, index bookkeeping and table-read selection.
    always_comb begin
        state_nx = state;
        idx_nx   = state_idx;
        loop_nx  = loop_idx;
        td_load  = 1'b0;
        td_addr  = 4'd0;
        case (state)
            IDLE: begin
                if (seq_start) begin
                    state_nx = ARM;
                    idx_nx   = 4'd0;
                    loop_nx  = 8'd0;
                    td_load  = 1'b1;
                end
            end
            ARM: state_nx = RUN;
            RUN: begin
                if (time_up) begin
                    if (state_idx < seq_len) begin
                        state_nx = ARM;
                        idx_nx   = state_idx + 4'd1;
                        td_load  = 1'b1;
                        td_addr  = state_idx + 4'd1;
                    end else if (loop_idx < loop_cnt) begin
                        state_nx = ARM;
                        idx_nx   = 4'd0;
                        loop_nx  = loop_idx + 8'd1;
                        td_load  = 1'b1;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // Abort wins over everything, including a simultaneous time_up.
        if (seq_abort) begin
            state_nx = IDLE;
            idx_nx   = state_idx;
            loop_nx  = loop_idx;
            td_load  = 1'b0;
        end
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            work_n       <= 1'b1;
            state_start  <= 1'b0;
            state_over_n <= 1'b1;
            busy         <= 1'b0;
            seq_done     <= 1'b0;
            timer_data   <= '0;
            state_idx    <= '0;
            loop_idx     <= '0;
        end else begin
            work_n       <= (state_nx == IDLE);
            state_start  <= (state_nx == RUN);
            state_over_n <= (state_nx != DONE);
            busy         <= (state_nx != IDLE);
            seq_done     <= (state_nx == DONE);
            state_idx    <= idx_nx;
            loop_idx     <= loop_nx;
            if (td_load) timer_data <= dur_of(tbl[td_addr]);
        end
    end

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Bench for pulse_seq_ctrl: behavioural interval timer, table of sequence
// vectors with a per-state scoreboard, plus directed abort/busy/reset cases.
module tb_pulse_seq_ctrl;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [21:0] cfg_data;
    logic [3:0]  seq_len;
    logic [7:0]  loop_cnt;
    logic        seq_start;
    logic        seq_abort;
    logic        time_up;
    logic [21:0] timer_data;
    logic        work_n, state_start, state_over_n, busy, seq_done;
    logic [3:0]  state_idx;
    logic [7:0]  loop_idx;

    pulse_seq_ctrl dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .seq_len(seq_len), .loop_cnt(loop_cnt),
        .seq_start(seq_start), .seq_abort(seq_abort), .time_up(time_up),
        .timer_data(timer_data), .work_n(work_n), .state_start(state_start),
        .state_over_n(state_over_n), .state_idx(state_idx), .loop_idx(loop_idx),
        .busy(busy), .seq_done(seq_done)
    );

    always #5 clk_sys = ~clk_sys;

    // Interval timer: counts cycles with state_start high, fires after timer_data.
    logic [21:0] tcnt;
    logic        tup, force_up;
    always @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= '0;
            tup  <= 1'b0;
        end else if (!state_start) begin
            tcnt <= '0;
            tup  <= 1'b0;
        end else begin
            tcnt <= tcnt + 22'd1;
            tup  <= (tcnt + 22'd1 == timer_data);
        end
    end
    assign time_up = tup | force_up;

    typedef struct {
        logic [15:0][21:0] dur;
        logic [3:0]        len;
        logic [7:0]        loops;
    } vec_t;

    typedef struct {
        logic [3:0]  idx;
        logic [7:0]  lp;
        logic [21:0] td;
    } exp_t;

    vec_t vecs[5];
    exp_t q[$];
    int   nvec = 0, nfail = 0, done_cnt = 0;

    function automatic logic [21:0] eff(input logic [21:0] d);
        return (d == 22'd0) ? 22'd1 : d;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: on each RUN entry pop the expected state and check
    // index/pass/duration; on RUN exit check how long state_start was high.
    logic ss_q = 1'b0;
    logic tracking = 1'b0;
    int   hi = 0, cur_len = 0;
    exp_t m_e;
    always @(negedge clk_sys) begin
        if (rst_n) begin
            if (state_start && !ss_q) begin
                if (q.size() > 0) begin
                    m_e = q.pop_front();
                    chk("state_idx", 64'(state_idx), 64'(m_e.idx));
                    chk("loop_idx", 64'(loop_idx), 64'(m_e.lp));
                    chk("timer_data", 64'(timer_data), 64'(m_e.td));
                    cur_len  = int'(m_e.td) + 1;
                    hi       = 1;
                    tracking = 1'b1;
                end else begin
                    tracking = 1'b0;
                end
            end else if (state_start) begin
                hi++;
            end else if (ss_q && tracking && busy) begin
                chk("start_len", 64'(hi), 64'(cur_len));
                tracking = 1'b0;
            end
            if (seq_done) done_cnt++;
        end
        ss_q = state_start;
    end

    task automatic write_table(input vec_t v);
        for (int i = 0; i < 16; i++) begin
            cfg_we   = 1'b1;
            cfg_addr = 4'(i);
            cfg_data = v.dur[i];
            @(negedge clk_sys);
        end
        cfg_we = 1'b0;
    endtask

    // Runs one full sequence; inject=1 pokes cfg_we and seq_start mid-run.
    task automatic run_seq(input vec_t v, input bit inject);
        int exp_cyc = 0;
        int n = 0;
        int d0;
        seq_len  = v.len;
        loop_cnt = v.loops;
        for (int p = 0; p <= int'(v.loops); p++)
            for (int i = 0; i <= int'(v.len); i++) begin
                q.push_back('{idx: 4'(i), lp: 8'(p), td: eff(v.dur[i])});
                exp_cyc += int'(eff(v.dur[i])) + 2;
            end
        d0 = done_cnt;
        @(negedge clk_sys);
        seq_start = 1'b1;
        @(negedge clk_sys);
        seq_start = 1'b0;
        chk("arm_entry", {busy, work_n, state_start, state_idx, loop_idx}, {1'b1, 1'b0, 1'b0, 12'd0});
        while (!seq_done && n < 5000) begin
            n++;
            if (inject && n == 3) begin
                cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 22'd99; seq_start = 1'b1;
            end
            if (inject && n == 5) begin
                cfg_we = 1'b0; seq_start = 1'b0;
            end
            @(negedge clk_sys);
        end
        cfg_we = 1'b0; seq_start = 1'b0;
        chk("seq_cycles", 64'(n), 64'(exp_cyc));
        chk("done_outs", {state_over_n, state_start, work_n, busy}, 4'b0001);
        @(negedge clk_sys);
        chk("idle_after", {work_n, busy, seq_done, state_start, state_over_n}, 5'b10001);
        chk("done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("sb_empty", 64'(q.size()), 64'd0);
    endtask

    // Starts a sequence by hand and waits for RUN of the given state.
    task automatic start_wait(input logic [3:0] idx, output bit ok);
        int n = 0;
        @(negedge clk_sys);
        seq_start = 1'b1;
        @(negedge clk_sys);
        seq_start = 1'b0;
        while (!(state_start && state_idx == idx) && n < 200) begin
            n++;
            @(negedge clk_sys);
        end
        ok = (n < 200);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit   ok;
        int   d0;
        vec_t vz;
        rst_n = 1'b0; cfg_we = 0; cfg_addr = 0; cfg_data = 0; seq_len = 0; loop_cnt = 0;
        seq_start = 0; seq_abort = 0; force_up = 0;

        vecs[0] = '{dur: '0, len: 4'd0, loops: 8'd0};
        vecs[0].dur[0] = 22'd3;
        vecs[1] = '{dur: '0, len: 4'd2, loops: 8'd1};
        vecs[1].dur[0] = 22'd5; vecs[1].dur[1] = 22'd2; vecs[1].dur[2] = 22'd7;
        vecs[2] = '{dur: '0, len: 4'd4, loops: 8'd0};
        vecs[2].dur[0] = 22'd1; vecs[2].dur[1] = 22'd2; vecs[2].dur[2] = 22'd1;
        vecs[2].dur[3] = 22'd3; vecs[2].dur[4] = 22'd0;
        vecs[3] = '{dur: '0, len: 4'd15, loops: 8'd0};
        for (int i = 0; i < 16; i++) vecs[3].dur[i] = 22'(i % 3);
        vecs[4] = '{dur: '0, len: 4'd1, loops: 8'd2};
        vecs[4].dur[0] = 22'd2;
        vz = '{dur: '0, len: 4'd15, loops: 8'd0};

        repeat (2) @(negedge clk_sys);
        chk("reset_outs", {work_n, state_start, state_over_n, busy, seq_done, timer_data, state_idx, loop_idx},
            {5'b10100, 22'd0, 4'd0, 8'd0});
        rst_n = 1'b1;
        @(negedge clk_sys);

        for (int k = 0; k < 5; k++) begin
            write_table(vecs[k]);
            run_seq(vecs[k], 1'b0);
        end

        // Table write and start request while busy must both be ignored.
        write_table(vecs[0]);
        run_seq(vecs[0], 1'b1);
        run_seq(vecs[0], 1'b0);

        // Abort together with time_up in RUN of state 1.
        write_table(vecs[1]);
        seq_len = 4'd2; loop_cnt = 8'd1;
        d0 = done_cnt;
        start_wait(4'd1, ok);
        chk("abort_reach", 64'(ok), 64'd1);
        seq_abort = 1'b1; force_up = 1'b1;
        @(negedge clk_sys);
        seq_abort = 1'b0; force_up = 1'b0;
        chk("abort_outs", {busy, work_n, state_start, state_over_n, seq_done}, 5'b01010);
        chk("abort_idx", 64'(state_idx), 64'd1);
        repeat (3) @(negedge clk_sys);
        chk("abort_stays", {busy, work_n}, 2'b01);
        chk("abort_nodone", 64'(done_cnt - d0), 64'd0);

        // Asynchronous reset in the middle of RUN.
        d0 = done_cnt;
        start_wait(4'd2, ok);
        chk("rst_reach", 64'(ok), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async", {work_n, state_start, state_over_n, busy, seq_done, timer_data, state_idx, loop_idx},
            {5'b10100, 22'd0, 4'd0, 8'd0});
        q.delete();
        @(negedge clk_sys);
        rst_n = 1'b1;
        @(negedge clk_sys);
        chk("rst_nodone", 64'(done_cnt - d0), 64'd0);
        run_seq(vz, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
